// File: rtl/vga_timing_pkg.sv
// Shared constants, widths and bus types for the character-grid raster timing generator.
// Defaults describe 640x480@60 with an 8x8 character cell.
package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int FRAME_W   = 8;

  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 8;
  localparam int SUBPIX_W  = $clog2(CHAR_W);
  localparam int SUBLINE_W = $clog2(CHAR_H);
  localparam int COL_W     = CNT_W - SUBPIX_W;
  localparam int LINE_W    = CNT_W - SUBLINE_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int MAX_ACTIVE     = 1016;
  localparam int MAX_TOTAL      = 1 << CNT_W;
  localparam int MAX_SYNC_DELAY = 7;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_bus_t;

  localparam int SYNC_BUS_W = $bits(sync_bus_t);

  typedef struct packed {
    logic [COL_W-1:0]     column;
    logic [LINE_W-1:0]    line;
    logic [SUBPIX_W-1:0]  pixel;
    logic [SUBLINE_W-1:0] subline;
  } char_coord_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that keeps sync/blank aligned with the pipelined pixel path.
// DEPTH = 0 collapses to a wire.
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_data = i_data;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // NOTE: stages are a handful of flops, not a RAM, so each one is reset to the idle sync level.
      always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_char_timing.sv
// Free-running raster counters, sync generation and character-grid coordinate decode.
// Sync and blank are delayed SYNC_DELAY cycles; coordinates and frame_start are not.
module vga_char_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 2
) (
  input  logic                 pixel_clock,
  input  logic                 reset,
  output logic [COL_W-1:0]     char_column,
  output logic [LINE_W-1:0]    char_line,
  output logic [SUBLINE_W-1:0] subchar_line,
  output logic [SUBPIX_W-1:0]  subchar_pixel,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic                 frame_start,
  output logic [FRAME_W-1:0]   frame_count
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CMP_W   = CNT_W + 1;

  // Boundaries are one bit wider than the counters so an end value of 1024 does not wrap.
  localparam logic [CMP_W-1:0] H_ACT_END   = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] H_SYNC_BEG  = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] H_SYNC_END  = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] V_ACT_END   = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] V_SYNC_BEG  = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] V_SYNC_END  = CMP_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);

  localparam sync_bus_t SYNC_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, active: 1'b0};

  generate
    if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_ACTIVE > MAX_ACTIVE || V_ACTIVE > MAX_ACTIVE ||
        H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
        SYNC_DELAY < 0 || SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_params
      $error("vga_char_timing: unsupported timing parameters");
    end
  endgenerate

  logic [CNT_W-1:0]   r_h_count;
  logic [CNT_W-1:0]   r_v_count;
  logic [FRAME_W-1:0] r_frame_count;
  logic               r_frame_start;

  logic               w_h_last;
  logic               w_v_last;
  logic [CMP_W-1:0]   w_h_ext;
  logic [CMP_W-1:0]   w_v_ext;
  logic               w_active_raw;
  sync_bus_t          w_sync_raw;
  sync_bus_t          w_sync_dly;
  char_coord_t        w_coord;

  assign w_h_last = (r_h_count == H_LAST);
  assign w_v_last = (r_v_count == V_LAST);
  assign w_h_ext  = {1'b0, r_h_count};
  assign w_v_ext  = {1'b0, r_v_count};

  // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of block order.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_frame_count <= '0;
      r_frame_start <= 1'b0;
    end else begin
      // Registered from the last pixel so the pulse lands on h=0,v=0 but never right after reset.
      r_frame_start <= w_h_last && w_v_last;
      if (w_h_last) begin
        r_h_count <= '0;
        if (w_v_last) begin
          r_v_count     <= '0;
          r_frame_count <= r_frame_count + 1'b1;
        end else begin
          r_v_count <= r_v_count + 1'b1;
        end
      end else begin
        r_h_count <= r_h_count + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_active_raw      = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
    w_sync_raw        = SYNC_IDLE;
    w_sync_raw.active = w_active_raw;
    if (w_h_ext >= H_SYNC_BEG && w_h_ext < H_SYNC_END) w_sync_raw.hsync = SYNC_POL;
    if (w_v_ext >= V_SYNC_BEG && w_v_ext < V_SYNC_END) w_sync_raw.vsync = SYNC_POL;
  end

  always_comb begin
    w_coord = '0;
    if (w_active_raw) begin
      w_coord.column  = r_h_count[CNT_W-1:SUBPIX_W];
      w_coord.pixel   = r_h_count[SUBPIX_W-1:0];
      w_coord.line    = r_v_count[CNT_W-1:SUBLINE_W];
      w_coord.subline = r_v_count[SUBLINE_W-1:0];
    end
  end

  sync_delay_line #(
    .WIDTH   (SYNC_BUS_W),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .i_data      (w_sync_raw),
    .o_data      (w_sync_dly)
  );

  assign hsync         = w_sync_dly.hsync;
  assign vsync         = w_sync_dly.vsync;
  assign video_on      = w_sync_dly.active;
  assign char_column   = w_coord.column;
  assign char_line     = w_coord.line;
  assign subchar_pixel = w_coord.pixel;
  assign subchar_line  = w_coord.subline;
  assign frame_start   = r_frame_start;
  assign frame_count   = r_frame_count;

endmodule

// File: doc/vga_char_timing.md
Name: vga_char_timing

Overview:
Raster timing generator that sits directly upstream of the character display stage. It free-runs horizontal and vertical pixel counters on pixel_clock and drives the HSYNC and VSYNC pins. It decodes the counters into the character-grid coordinates the display stage consumes: char_column, char_line, subchar_line and subchar_pixel. Sync and blank outputs are delayed by a programmable amount so they stay aligned with the character generator's pipelined pixel_on.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
SYNC_DELAY, 2, pipeline cycles applied to hsync/vsync/video_on (0..7)

Ports:
pixel_clock  in  1  pixel clock; only clock in the block
reset  in  1  asynchronous, active-low reset
char_column  out  7  h_count[9:3] during active video, else 0
char_line  out  7  v_count[9:3] during active video, else 0
subchar_pixel  out  3  h_count[2:0] during active video, else 0
subchar_line  out  3  v_count[2:0] during active video, else 0
hsync  out  1  horizontal sync, delayed SYNC_DELAY cycles
vsync  out  1  vertical sync, delayed SYNC_DELAY cycles
video_on  out  1  active-region flag, delayed SYNC_DELAY cycles
frame_start  out  1  one-cycle pulse at h_count=0, v_count=0 (undelayed)
frame_count  out  8  frames completed since reset, wraps 255->0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Counters are 10 bits.
- h_count: increments every cycle; on H_TOTAL-1 it wraps to 0.
- v_count: increments only on the cycle h_count = H_TOTAL-1; on V_TOTAL-1 with that condition it wraps to 0.
- active_raw = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- hsync_raw is asserted for H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vsync_raw is asserted for lines 490..491, over the whole line.
- Asserted level of hsync/vsync is SYNC_POL.
- Coordinate outputs are a zero-latency decode of the counter registers and change on the clock edge with the counters.
  - When active_raw = 0, all four coordinate outputs are 0.
  - Corner value: h=639, v=479 -> col 79, line 59, subpixel 7, subline 7.
- Delay line:
  - hsync_raw, vsync_raw and active_raw pass through a SYNC_DELAY-deep shift register; every stage is a register.
  - SYNC_DELAY = 0: the three signals are registered-free decodes.
  - Output at cycle t equals the raw value at cycle t-SYNC_DELAY.
- frame_start is high exactly in the cycle where h_count = 0 and v_count = 0.
  - It is not asserted in the first cycle after reset release.
  - First pulse comes after one full frame, at cycle 800*525 = 420000.
- frame_count increments on the cycle h_count = H_TOTAL-1 and v_count = V_TOTAL-1, so it changes together with the frame_start cycle. It wraps 255 -> 0.
- Reset (reset = 0, asynchronous):
  - h_count, v_count and frame_count go to 0.
  - All delay stages go to the inactive sync level (!SYNC_POL) and video_on = 0.
  - frame_start = 0.
  - Coordinates go to 0.
- Reset mid-frame aborts the frame immediately. Counting restarts at h=0, v=0 on the first clock edge after release, and outputs during the delay flush are the reset values.
- Counter decodes use only the constants from the parameters. Illegal values such as H_ACTIVE > 1016 are unsupported and guarded with a generate-time error.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480@60 porch/sync constants;
  - H_TOTAL/V_TOTAL derivation functions;
  - CHAR_W = 8, CHAR_H = 8 and the coordinate widths (7 for char_column/char_line, 3 for subchar_pixel/subchar_line).
- One sub-module, sync_delay_line:
  - WIDTH = 3, DEPTH = SYNC_DELAY shift register;
  - parameterised reset value;
  - clocked by pixel_clock with the same asynchronous active-low reset.

Test Plan:
- Reset held low 10 cycles, then released -> all outputs 0 except hsync/vsync = 1. At cycle 0 after release: char_column = 0, subchar_pixel = 0, video_on = 1 at cycle SYNC_DELAY.
- Run one line -> hsync low at cycles 658..753 (SYNC_DELAY = 2); video_on low from cycle 642; h_count wraps at 799, v_count becomes 1.
- Run to h = 639, v = 479 -> char_column = 79, char_line = 59, subchar_pixel = 7, subchar_line = 7. At h = 640, all four coordinates = 0.
- Run one full frame -> vsync low for exactly 1600 cycles (lines 490-491). frame_start pulses once at cycle 420000; frame_count = 1.
- Assert reset at h = 300, v = 200 -> outputs go to reset values asynchronously, before the next edge. After release, the sequence matches the first test exactly.
- Build with SYNC_DELAY = 0 and run 256 frames (sim) -> hsync asserted exactly at h = 656; frame_count wraps 255 -> 0 with frame_start coincident.
